// File: rtl/fan_speed_monitor.sv
// Fan controller: PWM drive, forced spin-up after enable, stall detection from the
// per-second tacho rate, and bounded spin-up retries before a latched fault.
module fan_speed_monitor #(
  parameter int         SPINUP_SECS = 3,
  parameter int         STALL_SECS  = 2,
  parameter logic [7:0] MIN_PPS     = 8'd4,
  parameter int         MAX_RETRIES = 2,
  parameter int         PWM_DIV     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_hz,
  input  logic [7:0] pulses_per_second,
  input  logic       enable,
  input  logic [7:0] duty,
  output logic       pwm_out,
  output logic       fan_ok,
  output logic       fan_fault,
  output logic [1:0] state,
  output logic [1:0] retries
);

  typedef enum logic [1:0] {IDLE = 2'd0, SPINUP = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;

  localparam logic [3:0] SPINUP_LIM = 4'(SPINUP_SECS);
  localparam logic [3:0] STALL_LIM  = 4'(STALL_SECS);
  localparam logic [2:0] RETRY_LIM  = 3'(MAX_RETRIES);
  localparam logic [7:0] PRE_MAX    = 8'(PWM_DIV - 1);

  state_t     state_reg;
  logic [3:0] sec_cnt_reg, stall_cnt_reg;
  logic [7:0] pre_reg, step_reg, duty_latched_reg;
  logic [1:0] retries_reg;
  logic       pwm_out_reg, fan_ok_reg, fan_fault_reg;

  logic       pre_wrap;
  logic [7:0] pre_next, step_next, duty_next;
  logic       pwm_raw_next;
  logic [3:0] sec_inc, stall_inc;
  logic [1:0] retries_inc;

  // PWM generator next values; duty only reloads at the end of a full period
  always_comb begin
    pre_wrap     = (pre_reg == PRE_MAX);
    pre_next     = pre_wrap ? 8'd0 : pre_reg + 8'd1;
    step_next    = pre_wrap ? step_reg + 8'd1 : step_reg;
    duty_next    = (pre_wrap && step_reg == 8'hFF) ? duty : duty_latched_reg;
    pwm_raw_next = (step_next < duty_next);
    sec_inc      = (sec_cnt_reg >= SPINUP_LIM) ? sec_cnt_reg : sec_cnt_reg + 4'd1;
    stall_inc    = (stall_cnt_reg >= STALL_LIM) ? stall_cnt_reg : stall_cnt_reg + 4'd1;
    retries_inc  = (retries_reg == 2'd3) ? retries_reg : retries_reg + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      sec_cnt_reg      <= 4'd0;
      stall_cnt_reg    <= 4'd0;
      pre_reg          <= 8'd0;
      step_reg         <= 8'd0;
      duty_latched_reg <= 8'd0;
      retries_reg      <= 2'd0;
      pwm_out_reg      <= 1'b0;
      fan_ok_reg       <= 1'b0;
      fan_fault_reg    <= 1'b0;
    end else if (!enable) begin
      state_reg     <= IDLE;
      pwm_out_reg   <= 1'b0;
      fan_ok_reg    <= 1'b0;
      fan_fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg   <= SPINUP;
          sec_cnt_reg <= 4'd0;
          retries_reg <= 2'd0;
          pwm_out_reg <= 1'b1;
        end
        SPINUP: begin
          pwm_out_reg <= 1'b1;
          if (one_hz) begin
            sec_cnt_reg <= sec_inc;
            if (sec_inc == SPINUP_LIM) begin
              // Restart the PWM period so the first RUN period is whole
              state_reg        <= RUN;
              stall_cnt_reg    <= 4'd0;
              fan_ok_reg       <= 1'b1;
              pre_reg          <= 8'd0;
              step_reg         <= 8'd0;
              duty_latched_reg <= duty;
              pwm_out_reg      <= (duty != 8'd0);
            end
          end
        end
        RUN: begin
          pre_reg          <= pre_next;
          step_reg         <= step_next;
          duty_latched_reg <= duty_next;
          pwm_out_reg      <= pwm_raw_next;
          if (one_hz) begin
            if (duty == 8'd0) begin
              stall_cnt_reg <= 4'd0;
            end else if (pulses_per_second < MIN_PPS) begin
              stall_cnt_reg <= stall_inc;
              if (stall_inc == STALL_LIM) begin
                fan_ok_reg  <= 1'b0;
                pwm_out_reg <= 1'b1;
                if ({1'b0, retries_reg} < RETRY_LIM) begin
                  state_reg   <= SPINUP;
                  sec_cnt_reg <= 4'd0;
                  retries_reg <= retries_inc;
                end else begin
                  state_reg     <= FAULT;
                  fan_fault_reg <= 1'b1;
                end
              end
            end else begin
              stall_cnt_reg <= 4'd0;
            end
          end
        end
        FAULT: begin
          pwm_out_reg   <= 1'b1;
          fan_fault_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pwm_out   = pwm_out_reg;
  assign fan_ok    = fan_ok_reg;
  assign fan_fault = fan_fault_reg;
  assign state     = state_reg;
  assign retries   = retries_reg;

endmodule

// File: tb/tb_fan_speed_monitor.sv
// Directed bench for fan_speed_monitor with default parameters (spin-up 3 s,
// stall 2 s, MIN_PPS 4, 2 retries, PWM_DIV 8 -> 2048-clock PWM period).
module tb_fan_speed_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_hz = 1'b0;
  logic [7:0] pulses_per_second = 8'd0;
  logic       enable = 1'b0;
  logic [7:0] duty = 8'd0;
  logic       pwm_out, fan_ok, fan_fault;
  logic [1:0] state, retries;

  int n_checks = 0;
  int n_fails  = 0;
  int high_cnt;

  fan_speed_monitor dut (
    .clk(clk), .reset(reset), .one_hz(one_hz), .pulses_per_second(pulses_per_second),
    .enable(enable), .duty(duty), .pwm_out(pwm_out), .fan_ok(fan_ok),
    .fan_fault(fan_fault), .state(state), .retries(retries)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] pps);
    pulses_per_second = pps;
    one_hz = 1'b1;
    tick();
    one_hz = 1'b0;
    tick();
    tick();
  endtask

  task automatic strobes(input int n, input logic [7:0] pps);
    for (int i = 0; i < n; i++) strobe(pps);
  endtask

  task automatic measure_high(output int hc);
    hc = 0;
    for (int i = 0; i < 2048; i++) begin
      if (pwm_out) hc++;
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_ok", fan_ok, 0);
    check("rst_fault", fan_fault, 0);
    check("rst_retries", retries, 0);
    reset = 1'b0;
    tick();

    // Nominal start
    duty = 8'd128;
    pulses_per_second = 8'd50;
    enable = 1'b1;
    tick();
    check("en_state", state, 1);
    check("en_pwm", pwm_out, 1);
    strobes(2, 8'd50);
    check("spin2_state", state, 1);
    check("spin2_pwm", pwm_out, 1);
    strobe(8'd50);
    check("run_state", state, 2);
    check("run_ok", fan_ok, 1);
    measure_high(high_cnt);
    check("pwm128_high", high_cnt, 1024);

    // Stall with recovery
    strobe(8'd2);
    check("stall1_state", state, 2);
    strobe(8'd2);
    check("stall2_state", state, 1);
    check("stall2_retries", retries, 1);
    strobes(3, 8'd50);
    check("recover_state", state, 2);
    check("recover_fault", fan_fault, 0);

    // Boundary rate
    strobes(4, 8'd4);
    check("pps4_state", state, 2);
    strobe(8'd3);
    strobe(8'd4);
    strobe(8'd3);
    check("pps343_state", state, 2);
    strobe(8'd4);

    // Intentional stop, then duty 255
    duty = 8'd0;
    repeat (2048) tick();
    strobes(10, 8'd0);
    check("stop_state", state, 2);
    check("stop_pwm", pwm_out, 0);
    measure_high(high_cnt);
    check("pwm0_high", high_cnt, 0);
    duty = 8'd255;
    pulses_per_second = 8'd50;
    repeat (2048) tick();
    measure_high(high_cnt);
    check("pwm255_high", high_cnt, 2040);
    strobe(8'd0);
    check("d255_stall1_state", state, 2);
    strobe(8'd0);
    check("d255_stall2_state", state, 1);
    check("d255_stall2_retries", retries, 2);

    // Exhausting retries from a fresh enable
    enable = 1'b0;
    tick();
    check("dis_state", state, 0);
    check("dis_pwm", pwm_out, 0);
    duty = 8'd128;
    enable = 1'b1;
    tick();
    check("ex_en_state", state, 1);
    check("ex_en_retries", retries, 0);
    strobes(3, 8'd0);
    check("ex_run0", state, 2);
    strobes(2, 8'd0);
    check("ex_spin1", state, 1);
    check("ex_spin1_retries", retries, 1);
    strobes(3, 8'd0);
    check("ex_run1", state, 2);
    strobes(2, 8'd0);
    check("ex_spin2", state, 1);
    check("ex_spin2_retries", retries, 2);
    strobes(3, 8'd0);
    check("ex_run2", state, 2);
    strobes(2, 8'd0);
    check("ex_fault_state", state, 3);
    check("ex_fault_flag", fan_fault, 1);
    check("ex_fault_pwm", pwm_out, 1);
    check("ex_fault_ok", fan_ok, 0);
    strobes(2, 8'd50);
    check("ex_fault_hold", state, 3);
    enable = 1'b0;
    tick();
    check("ex_idle_state", state, 0);
    check("ex_idle_pwm", pwm_out, 0);
    check("ex_idle_fault", fan_fault, 0);

    // enable=0 beats a simultaneous stall strobe
    enable = 1'b1;
    tick();
    strobes(3, 8'd0);
    check("prio_run", state, 2);
    strobe(8'd0);
    pulses_per_second = 8'd0;
    one_hz = 1'b1;
    enable = 1'b0;
    tick();
    one_hz = 1'b0;
    check("prio_state", state, 0);
    check("prio_pwm", pwm_out, 0);

    // Asynchronous reset mid spin-up
    enable = 1'b1;
    tick();
    strobe(8'd50);
    check("arst_pre_state", state, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_state", state, 0);
    check("arst_pwm", pwm_out, 0);
    check("arst_retries", retries, 0);
    enable = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("arst_release_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
